// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the control unit and a byte-addressed data RAM.
// Splits doubleword and SWAP requests into two RAM accesses and extends load data.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned EN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    output logic              rsp_valid,
    output logic [1:0]        rsp_trap,
    output logic [31:0]       rsp_rdata0,
    output logic [31:0]       rsp_rdata1,
    output logic              ram_en,
    output logic [5:0]        ram_op,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_SWAP = 6'b001111;

    localparam logic [5:0] CMD_WR_WORD = 6'b000000;
    localparam logic [5:0] CMD_WR_BYTE = 6'b000001;
    localparam logic [5:0] CMD_WR_HALF = 6'b000010;
    localparam logic [5:0] CMD_RD_WORD = 6'b000100;
    localparam logic [5:0] CMD_RD_BYTE = 6'b000101;
    localparam logic [5:0] CMD_RD_HALF = 6'b000110;

    localparam logic [1:0] TRAP_OK    = 2'b00;
    localparam logic [1:0] TRAP_ALIGN = 2'b01;
    localparam logic [1:0] TRAP_ILL   = 2'b10;

    localparam logic [3:0] LAST_CNT = 4'(EN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata0_q;
    logic [31:0]       wdata1_q;
    logic [3:0]        cnt;
    logic              gap;
    logic              last_c;
    logic [1:0]        req_trap_c;

    function automatic logic [5:0] ram_cmd(input logic [5:0] op);
        case (op)
            OP_LD, OP_LDD, OP_SWAP: ram_cmd = CMD_RD_WORD;
            OP_LDUB, OP_LDSB:       ram_cmd = CMD_RD_BYTE;
            OP_LDUH, OP_LDSH:       ram_cmd = CMD_RD_HALF;
            OP_STB:                 ram_cmd = CMD_WR_BYTE;
            OP_STH:                 ram_cmd = CMD_WR_HALF;
            default:                ram_cmd = CMD_WR_WORD;
        endcase
    endfunction

    // Narrow stores travel in the high-order lanes of the RAM write bus
    function automatic logic [31:0] wr_data(input logic [5:0] op, input logic [31:0] w);
        case (op)
            OP_STB:  wr_data = {w[7:0], 24'h0};
            OP_STH:  wr_data = {w[15:0], 16'h0};
            default: wr_data = w;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [31:0] rd);
        case (op)
            OP_LDUB: load_ext = {24'h0, rd[7:0]};
            OP_LDSB: load_ext = {{24{rd[7]}}, rd[7:0]};
            OP_LDUH: load_ext = {16'h0, rd[15:0]};
            OP_LDSH: load_ext = {{16{rd[15]}}, rd[15:0]};
            default: load_ext = rd;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        is_load = (op == OP_LD) || (op == OP_LDUB) || (op == OP_LDUH) || (op == OP_LDD) ||
                  (op == OP_LDSB) || (op == OP_LDSH) || (op == OP_SWAP);
    endfunction

    function automatic logic two_acc(input logic [5:0] op);
        two_acc = (op == OP_LDD) || (op == OP_STD) || (op == OP_SWAP);
    endfunction

    // Trap classification of the incoming request
    always_comb begin
        req_trap_c = TRAP_OK;
        case (req_op)
            OP_LDUB, OP_LDSB, OP_STB: req_trap_c = TRAP_OK;
            OP_LDUH, OP_LDSH, OP_STH:
                if (req_addr[0] != 1'b0) req_trap_c = TRAP_ALIGN;
            OP_LD, OP_ST, OP_SWAP:
                if (req_addr[1:0] != 2'b00) req_trap_c = TRAP_ALIGN;
            OP_LDD, OP_STD:
                if (req_addr[2:0] != 3'b000) req_trap_c = TRAP_ALIGN;
            default: req_trap_c = TRAP_ILL;
        endcase
    end

    assign last_c = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_trap   <= TRAP_OK;
            rsp_rdata0 <= 32'h0;
            rsp_rdata1 <= 32'h0;
            ram_en     <= 1'b0;
            ram_op     <= 6'h0;
            ram_addr   <= '0;
            ram_wdata  <= 32'h0;
            op_q       <= 6'h0;
            addr_q     <= '0;
            wdata0_q   <= 32'h0;
            wdata1_q   <= 32'h0;
            cnt        <= 4'h0;
            gap        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_q    <= req_addr;
                        wdata0_q  <= req_wdata0;
                        wdata1_q  <= req_wdata1;
                        req_ready <= 1'b0;
                        cnt       <= 4'h0;
                        if (req_trap_c != TRAP_OK) begin
                            rsp_trap  <= req_trap_c;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_op    <= ram_cmd(req_op);
                            ram_addr  <= req_addr;
                            ram_wdata <= wr_data(req_op, req_wdata0);
                            state     <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (last_c) begin
                        ram_en <= 1'b0;
                        cnt    <= 4'h0;
                        if (is_load(op_q)) rsp_rdata0 <= load_ext(op_q, ram_rdata);
                        if (two_acc(op_q)) begin
                            gap   <= 1'b1;
                            state <= ACC1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_trap  <= TRAP_OK;
                            state     <= RESP;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACC1: begin
                    // First ACC1 cycle is the enable gap; the second access is set up here
                    if (gap) begin
                        gap    <= 1'b0;
                        ram_en <= 1'b1;
                        if (op_q == OP_SWAP) begin
                            ram_op    <= CMD_WR_WORD;
                            ram_addr  <= addr_q;
                            ram_wdata <= wdata0_q;
                        end else if (op_q == OP_STD) begin
                            ram_op    <= CMD_WR_WORD;
                            ram_addr  <= addr_q + ADDR_W'(4);
                            ram_wdata <= wdata1_q;
                        end else begin
                            ram_op   <= CMD_RD_WORD;
                            ram_addr <= addr_q + ADDR_W'(4);
                        end
                    end else if (last_c) begin
                        ram_en    <= 1'b0;
                        cnt       <= 4'h0;
                        if (op_q == OP_LDD) rsp_rdata1 <= ram_rdata;
                        rsp_valid <= 1'b1;
                        rsp_trap  <= TRAP_OK;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with EN_CYCLES=1, one with EN_CYCLES=3,
// each held in reset while the other is exercised.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n1, reset_n3;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata0, req_wdata1, ram_rdata;

    logic        r1_ready, r1_rv, r1_en, r3_ready, r3_rv, r3_en;
    logic [1:0]  r1_trap, r3_trap;
    logic [31:0] r1_rd0, r1_rd1, r1_wd, r3_rd0, r3_rd1, r3_wd;
    logic [5:0]  r1_op, r3_op;
    logic [7:0]  r1_addr, r3_addr;

    logic        use3 = 1'b0;
    wire         x_ready = use3 ? r3_ready : r1_ready;
    wire         x_rv    = use3 ? r3_rv    : r1_rv;
    wire         x_en    = use3 ? r3_en    : r1_en;
    wire [1:0]   x_trap  = use3 ? r3_trap  : r1_trap;
    wire [31:0]  x_rd0   = use3 ? r3_rd0   : r1_rd0;
    wire [31:0]  x_rd1   = use3 ? r3_rd1   : r1_rd1;
    wire [31:0]  x_wd    = use3 ? r3_wd    : r1_wd;
    wire [5:0]   x_op    = use3 ? r3_op    : r1_op;
    wire [7:0]   x_addr  = use3 ? r3_addr  : r1_addr;

    int checks = 0;
    int errors = 0;

    int          n_pulse, en_total, lat, seen;
    int          p_start [2];
    logic [5:0]  p_op    [2];
    logic [7:0]  p_addr  [2];
    logic [31:0] p_wd    [2];
    logic [1:0]  got_trap;
    logic        prev_en;

    mem_access_ctrl #(.ADDR_W(8), .EN_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n1), .req_valid(req_valid), .req_ready(r1_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(r1_rv), .rsp_trap(r1_trap), .rsp_rdata0(r1_rd0), .rsp_rdata1(r1_rd1),
        .ram_en(r1_en), .ram_op(r1_op), .ram_addr(r1_addr), .ram_wdata(r1_wd), .ram_rdata(ram_rdata)
    );

    mem_access_ctrl #(.ADDR_W(8), .EN_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n3), .req_valid(req_valid), .req_ready(r3_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(r3_rv), .rsp_trap(r3_trap), .rsp_rdata0(r3_rd0), .rsp_rdata1(r3_rd1),
        .ram_en(r3_en), .ram_op(r3_op), .ram_addr(r3_addr), .ram_wdata(r3_wd), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and record RAM pulses and response latency (cycles after accept edge)
    task automatic run(input logic [5:0] op, input logic [7:0] addr,
                       input logic [31:0] w0, input logic [31:0] w1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata0 = w0; req_wdata1 = w1;
        n_pulse = 0; en_total = 0; lat = 0; prev_en = 1'b0; got_trap = 2'b11;
        p_start[1] = 0;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (x_en) en_total++;
            if (x_en && !prev_en && n_pulse < 2) begin
                p_start[n_pulse] = k;
                p_op[n_pulse]    = x_op;
                p_addr[n_pulse]  = x_addr;
                p_wd[n_pulse]    = x_wd;
                n_pulse++;
            end
            prev_en = x_en;
            if (x_rv) begin
                lat      = k;
                got_trap = x_trap;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        reset_n1 = 1'b0; reset_n3 = 1'b0; req_valid = 1'b0; req_op = 6'h0; req_addr = 8'h0;
        req_wdata0 = 32'h0; req_wdata1 = 32'h0; ram_rdata = 32'h0;
        tick(); tick();
        chk("rst_ready", x_ready, 1);
        chk("rst_rsp_valid", x_rv, 0);
        chk("rst_ram_en", x_en, 0);
        chk("rst_ram_op", x_op, 0);
        chk("rst_ram_addr", x_addr, 0);
        chk("rst_rdata0", x_rd0, 0);
        chk("rst_trap", x_trap, 0);
        reset_n1 = 1'b1;
        tick();

        run(6'b000101, 8'h10, 32'h000000A5, 32'h0);
        chk("stb_pulses", n_pulse, 1);
        chk("stb_en_cycles", en_total, 1);
        chk("stb_op", p_op[0], 6'b000001);
        chk("stb_addr", p_addr[0], 8'h10);
        chk("stb_wdata", p_wd[0], 32'hA5000000);
        chk("stb_lat", lat, 2);
        chk("stb_trap", got_trap, 0);
        chk("rsp_one_cycle", x_rv, 0);
        chk("ready_after_rsp", x_ready, 1);

        ram_rdata = 32'h000000A5;
        run(6'b001001, 8'h10, 32'h0, 32'h0);
        chk("ldsb_op", p_op[0], 6'b000101);
        chk("ldsb_data", x_rd0, 32'hFFFFFFA5);
        chk("ldsb_lat", lat, 2);
        run(6'b000001, 8'h10, 32'h0, 32'h0);
        chk("ldub_data", x_rd0, 32'h000000A5);
        ram_rdata = 32'h00007FFF;
        run(6'b001010, 8'h12, 32'h0, 32'h0);
        chk("ldsh_op", p_op[0], 6'b000110);
        chk("ldsh_pos", x_rd0, 32'h00007FFF);
        ram_rdata = 32'h12348000;
        run(6'b000010, 8'h12, 32'h0, 32'h0);
        chk("lduh_data", x_rd0, 32'h00008000);
        run(6'b001010, 8'h12, 32'h0, 32'h0);
        chk("ldsh_neg", x_rd0, 32'hFFFF8000);

        run(6'b000111, 8'h20, 32'h11111111, 32'h22222222);
        chk("std_pulses", n_pulse, 2);
        chk("std_en_cycles", en_total, 2);
        chk("std_op0", p_op[0], 6'b000000);
        chk("std_addr0", p_addr[0], 8'h20);
        chk("std_wd0", p_wd[0], 32'h11111111);
        chk("std_op1", p_op[1], 6'b000000);
        chk("std_addr1", p_addr[1], 8'h24);
        chk("std_wd1", p_wd[1], 32'h22222222);
        chk("std_gap", p_start[1], 3);
        chk("std_lat", lat, 4);
        chk("std_rdata_kept", x_rd0, 32'hFFFF8000);

        ram_rdata = 32'h12345678;
        run(6'b001111, 8'h40, 32'hDEADBEEF, 32'h0);
        chk("swap_op0", p_op[0], 6'b000100);
        chk("swap_addr0", p_addr[0], 8'h40);
        chk("swap_op1", p_op[1], 6'b000000);
        chk("swap_addr1", p_addr[1], 8'h40);
        chk("swap_wd1", p_wd[1], 32'hDEADBEEF);
        chk("swap_old", x_rd0, 32'h12345678);
        chk("swap_lat", lat, 4);
        chk("hold_addr", x_addr, 8'h40);

        run(6'b000000, 8'h42, 32'h0, 32'h0);
        chk("ld_mis_pulses", n_pulse, 0);
        chk("ld_mis_lat", lat, 1);
        chk("ld_mis_trap", got_trap, 2'b01);
        chk("trap_rdata_kept", x_rd0, 32'h12345678);
        run(6'b001011, 8'h00, 32'h0, 32'h0);
        chk("ill_trap", got_trap, 2'b10);
        chk("ill_pulses", n_pulse, 0);
        run(6'b000011, 8'h44, 32'h0, 32'h0);
        chk("ldd_mis_trap", got_trap, 2'b01);
        run(6'b000110, 8'h11, 32'h0, 32'h0);
        chk("sth_mis_trap", got_trap, 2'b01);

        // EN_CYCLES=3 instance
        reset_n1 = 1'b0;
        use3 = 1'b1;
        reset_n3 = 1'b1;
        tick();
        ram_rdata = 32'hAABBCCDD;
        run(6'b000011, 8'h10, 32'h0, 32'h0);
        chk("ldd3_pulses", n_pulse, 2);
        chk("ldd3_en_cycles", en_total, 6);
        chk("ldd3_gap", p_start[1], 5);
        chk("ldd3_addr1", p_addr[1], 8'h14);
        chk("ldd3_op1", p_op[1], 6'b000100);
        chk("ldd3_lat", lat, 8);
        chk("ldd3_rd0", x_rd0, 32'hAABBCCDD);
        chk("ldd3_rd1", x_rd1, 32'hAABBCCDD);

        req_valid = 1'b1; req_op = 6'b000011; req_addr = 8'h08;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("acc1_en", x_en, 1);
        reset_n3 = 1'b0;
        #1;
        chk("abort_en", x_en, 0);
        chk("abort_ready", x_ready, 1);
        chk("abort_rd1", x_rd1, 0);
        tick();
        reset_n3 = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (x_rv) seen++;
            tick();
        end
        chk("abort_no_rsp", seen, 0);
        chk("ready_after_abort", x_ready, 1);

        ram_rdata = 32'hCAFEF00D;
        run(6'b000000, 8'h0C, 32'h0, 32'h0);
        chk("ld3_lat", lat, 4);
        chk("ld3_en_cycles", en_total, 3);
        chk("ld3_trap", got_trap, 0);
        chk("ld3_data", x_rd0, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
